// File: rtl/mult_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : mult_rr_scheduler
// Description : Round-robin arbiter that shares one unsigned shift-add
//               multiplier among NREQ valid/ready requesters. It performs one
//               operation at a time and returns the product tagged with the
//               index of the requester that issued it.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_rr_scheduler #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4,
    parameter int IDW   = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    output logic [NREQ-1:0]         req_ready,
    output logic                    rsp_valid,
    output logic [IDW-1:0]          rsp_id,
    output logic [2*WIDTH-1:0]      rsp_prod,
    output logic                    busy
);

    localparam int CNTW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q,     state_d;
    logic [IDW-1:0]     rr_ptr_q,    rr_ptr_d;
    logic [WIDTH-1:0]   a_q,         a_d;
    logic [WIDTH-1:0]   b_q,         b_d;
    logic [IDW-1:0]     id_q,        id_d;
    logic [2*WIDTH-1:0] acc_q,       acc_d;
    logic [CNTW-1:0]    cnt_q,       cnt_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]     rsp_id_q,    rsp_id_d;
    logic [2*WIDTH-1:0] rsp_prod_q,  rsp_prod_d;

    logic               w_found;
    logic [IDW-1:0]     w_sel_id;
    logic [IDW-1:0]     w_next_ptr;
    logic [IDW:0]       w_idx;
    logic [NREQ-1:0]    w_grant;

    // Round-robin search: first valid requester at or after rr_ptr, wrapping
    always_comb begin
        w_found    = 1'b0;
        w_sel_id   = '0;
        w_idx      = '0;
        w_grant    = '0;
        w_next_ptr = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = {1'b0, rr_ptr_q} + (IDW+1)'(k);
            if (w_idx >= (IDW+1)'(NREQ)) begin
                w_idx = w_idx - (IDW+1)'(NREQ);
            end
            if (!w_found && req_valid[w_idx]) begin
                w_found  = 1'b1;
                w_sel_id = w_idx[IDW-1:0];
            end
        end
        w_grant[w_sel_id] = w_found;
        // Pointer moves to the requester just after the one granted
        w_next_ptr = (w_sel_id == IDW'(NREQ-1)) ? '0 : w_sel_id + 1'b1;
    end

    // Next-state, datapath and response update for the IDLE/CALC/DONE sequence
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        a_d         = a_q;
        b_d         = b_q;
        id_d        = id_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        rsp_valid_d = 1'b0;
        rsp_id_d    = rsp_id_q;
        rsp_prod_d  = rsp_prod_q;
        case (state_q)
            ST_IDLE: begin
                if (w_found) begin
                    a_d      = req_a[w_sel_id*WIDTH +: WIDTH];
                    b_d      = req_b[w_sel_id*WIDTH +: WIDTH];
                    id_d     = w_sel_id;
                    acc_d    = '0;
                    cnt_d    = '0;
                    rr_ptr_d = w_next_ptr;
                    state_d  = ST_CALC;
                end
            end
            ST_CALC: begin
                if (b_q[cnt_q]) begin
                    acc_d = acc_q + ({{WIDTH{1'b0}}, a_q} << cnt_q);
                end
                cnt_d = cnt_q + 1'b1;
                // The response registers load on the last step so the pulse
                // coincides exactly with the DONE cycle
                if (cnt_q == CNTW'(WIDTH-1)) begin
                    state_d     = ST_DONE;
                    rsp_valid_d = 1'b1;
                    rsp_prod_d  = acc_d;
                    rsp_id_d    = id_q;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            a_q         <= '0;
            b_q         <= '0;
            id_q        <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_prod_q  <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            a_q         <= a_d;
            b_q         <= b_d;
            id_q        <= id_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_prod_q  <= rsp_prod_d;
        end
    end

    // Outputs; handshake and status are masked while reset is asserted so an
    // abandoned operation can never be observed
    always_comb begin
        req_ready = (state_q == ST_IDLE && !rst) ? w_grant : '0;
        rsp_valid = rsp_valid_q && !rst;
        rsp_id    = rsp_id_q;
        rsp_prod  = rsp_prod_q;
        busy      = (state_q != ST_IDLE) && !rst;
    end

endmodule
`default_nettype wire

// File: tb/tb_mult_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_rr_scheduler
// Description : Scoreboard bench for mult_rr_scheduler. A negedge monitor
//               logs grants, queues expected responses, and checks each
//               response's id, product and arrival cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_rr_scheduler;

    localparam int NREQ  = 4;
    localparam int WIDTH = 4;
    localparam int IDW   = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       req_ready;
    logic                  rsp_valid;
    logic [IDW-1:0]        rsp_id;
    logic [2*WIDTH-1:0]    rsp_prod;
    logic                  busy;

    mult_rr_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_prod  (rsp_prod),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Number of rising edges seen so far
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int id; int prod; int due; } exp_t;
    typedef struct { int id; int cyc; } gnt_t;

    exp_t            sb[$];
    gnt_t            glog[$];
    int              n_checks = 0;
    int              n_pass   = 0;
    int              rsp_count = 0;
    int              last_id, last_prod, last_cyc;
    logic [NREQ-1:0] gmask;

    int              m_id;
    exp_t            m_e;
    int              m_a, m_b;

    // Monitor: score responses and record grants, sampled mid-cycle
    always @(negedge clk) begin
        gmask = '0;
        if (rst) begin
            sb.delete();
        end else begin
            if (rsp_valid) begin
                rsp_count++;
                last_id   = int'(rsp_id);
                last_prod = int'(rsp_prod);
                last_cyc  = cyc;
                n_checks++;
                if (sb.size() == 0) begin
                    $display("FAIL unexpected_rsp: got rsp id=%0d prod=%0d at cycle %0d, expected none", rsp_id, rsp_prod, cyc);
                end else begin
                    n_pass++;
                    m_e = sb.pop_front();
                    n_checks++;
                    if (int'(rsp_id) !== m_e.id) $display("FAIL rsp_id: got %0d expected %0d", rsp_id, m_e.id);
                    else n_pass++;
                    n_checks++;
                    if (int'(rsp_prod) !== m_e.prod) $display("FAIL rsp_prod: got %0d expected %0d", rsp_prod, m_e.prod);
                    else n_pass++;
                    n_checks++;
                    if (cyc !== m_e.due) $display("FAIL rsp_latency: got cycle %0d expected %0d", cyc, m_e.due);
                    else n_pass++;
                    n_checks++;
                    if (busy !== 1'b1) $display("FAIL busy_in_done: got %0b expected 1", busy);
                    else n_pass++;
                end
            end
            if ((req_valid & req_ready) != '0) begin
                n_checks++;
                if ($countones(req_ready) != 1) $display("FAIL grant_onehot: got %b expected one-hot", req_ready);
                else n_pass++;
                m_id = 0;
                for (int k = 0; k < NREQ; k++) if (req_ready[k]) m_id = k;
                m_a = int'(req_a[m_id*WIDTH +: WIDTH]);
                m_b = int'(req_b[m_id*WIDTH +: WIDTH]);
                sb.push_back('{id: m_id, prod: m_a * m_b, due: cyc + 1 + WIDTH});
                glog.push_back('{id: m_id, cyc: cyc + 1});
                gmask = req_ready;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int id, input int a, input int b);
        req_a[id*WIDTH +: WIDTH] = WIDTH'(a);
        req_b[id*WIDTH +: WIDTH] = WIDTH'(b);
    endtask

    // Run until glog holds n grants; optionally withdraw each granted request
    task automatic wait_grants(input int n, input bit drop);
        int t;
        for (t = 0; t < 200; t++) begin
            tick();
            if (drop) req_valid = req_valid & ~gmask;
            if (glog.size() >= n) break;
        end
        if (t == 200) begin
            n_checks++;
            $display("FAIL grant_timeout: got %0d grants expected %0d", glog.size(), n);
        end
    endtask

    task automatic wait_idle();
        int t;
        for (t = 0; t < 100; t++) begin
            tick();
            if (sb.size() == 0 && busy === 1'b0) break;
        end
        n_checks++;
        if (t == 100) $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
        else n_pass++;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = '1;
        req_a     = '0;
        req_b     = '0;
        drive(0, 3, 5);
        drive(1, 7, 2);
        drive(2, 11, 9);
        drive(3, 15, 14);
        repeat (5) begin
            @(negedge clk);
            n_checks++;
            if (req_ready !== '0) $display("FAIL reset_ready: got %b expected 0000", req_ready);
            else n_pass++;
            n_checks++;
            if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid);
            else n_pass++;
            n_checks++;
            if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy);
            else n_pass++;
        end
        n_checks++;
        if (rsp_id !== '0) $display("FAIL reset_rsp_id: got %0d expected 0", rsp_id);
        else n_pass++;
        n_checks++;
        if (rsp_prod !== '0) $display("FAIL reset_rsp_prod: got %0d expected 0", rsp_prod);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        glog.delete();
        tick();
        rst = 1'b0;
        wait_grants(5, 1'b0);
        req_valid = '0;
        for (int i = 0; i < 5 && i < glog.size(); i++) begin
            n_checks++;
            if (glog[i].id !== i % NREQ) $display("FAIL rr_order[%0d]: got %0d expected %0d", i, glog[i].id, i % NREQ);
            else n_pass++;
            if (i > 0) begin
                n_checks++;
                if (glog[i].cyc - glog[i-1].cyc !== WIDTH + 2)
                    $display("FAIL rr_spacing[%0d]: got %0d expected %0d", i, glog[i].cyc - glog[i-1].cyc, WIDTH + 2);
                else n_pass++;
            end
        end
        wait_idle();
    endtask

    task automatic test_single();
        glog.delete();
        drive(0, 13, 10);
        req_valid = 4'b0001;
        wait_grants(1, 1'b1);
        wait_idle();
        n_checks++;
        if (last_prod !== 130 || last_id !== 0)
            $display("FAIL single_rsp: got id=%0d prod=%0d expected id=0 prod=130", last_id, last_prod);
        else n_pass++;
        n_checks++;
        if (glog.size() == 0 || last_cyc !== glog[0].cyc + WIDTH)
            $display("FAIL single_latency: got cycle %0d expected grant+%0d", last_cyc, WIDTH);
        else n_pass++;
    endtask

    task automatic test_corners();
        int ca[4] = '{15, 0, 9, 1};
        int cb[4] = '{15, 9, 0, 1};
        int cp[4] = '{225, 0, 0, 1};
        for (int i = 0; i < 4; i++) begin
            glog.delete();
            drive(1, ca[i], cb[i]);
            req_valid = 4'b0010;
            wait_grants(1, 1'b1);
            wait_idle();
            n_checks++;
            if (last_prod !== cp[i] || last_id !== 1)
                $display("FAIL corner[%0d]: got id=%0d prod=%0d expected id=1 prod=%0d", i, last_id, last_prod, cp[i]);
            else n_pass++;
        end
    endtask

    task automatic test_rr_pointer();
        glog.delete();
        drive(2, 5, 6);
        req_valid = 4'b0100;
        wait_grants(1, 1'b1);
        wait_idle();
        repeat (3) tick();
        drive(1, 12, 3);
        drive(3, 6, 7);
        req_valid = 4'b1010;
        wait_grants(3, 1'b1);
        n_checks++;
        if (glog.size() < 3 || glog[1].id !== 3 || glog[2].id !== 1)
            $display("FAIL rr_pointer: got %0d then %0d expected 3 then 1",
                     (glog.size() > 1) ? glog[1].id : -1, (glog.size() > 2) ? glog[2].id : -1);
        else n_pass++;
        wait_idle();
    endtask

    task automatic test_reset_mid();
        int rsp_before;
        glog.delete();
        drive(2, 14, 13);
        req_valid = 4'b0100;
        wait_grants(1, 1'b1);
        tick();
        tick();
        rsp_before = rsp_count;
        rst = 1'b1;
        drive(0, 11, 7);
        drive(2, 8, 9);
        req_valid = 4'b0101;
        @(negedge clk);
        n_checks++;
        if (req_ready !== '0) $display("FAIL midreset_ready: got %b expected 0000", req_ready);
        else n_pass++;
        tick();
        rst = 1'b0;
        glog.delete();
        wait_grants(2, 1'b1);
        n_checks++;
        if (glog.size() < 2 || glog[0].id !== 0 || glog[1].id !== 2)
            $display("FAIL midreset_order: got %0d then %0d expected 0 then 2",
                     (glog.size() > 0) ? glog[0].id : -1, (glog.size() > 1) ? glog[1].id : -1);
        else n_pass++;
        wait_idle();
        n_checks++;
        if (rsp_count - rsp_before !== 2)
            $display("FAIL midreset_rsp_count: got %0d expected 2", rsp_count - rsp_before);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_corners();
        test_rr_pointer();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
